divider: RTL and testbench
==========================

# divider

Iterative 32-bit radix-2 divider that answers the EXE stage's multi-cycle start/finish handshake for DIV/DIVU, in the same way the multiplier answers MULT. EXE holds `div_begin` high while a valid divide instruction is in EXE. The block computes quotient and remainder over 32 iterations, then pulses `div_end` so EXE can assert EXE_over. EXE routes the remainder to HI and the quotient to LO.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; only 32 is supported by the pipeline.

Ports:
- `clk`  in  1  rising-edge clock; the block's only clock.
- `reset`  in  1  synchronous, active-high reset.
- `div_begin`  in  1  level request; high while a valid divide is in EXE; dropping it cancels the operation.
- `div_signed`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled at start.
- `div_op1`  in  32  dividend (EXE alu_operand1); sampled at start.
- `div_op2`  in  32  divisor (EXE alu_operand2); sampled at start.
- `quotient`  out  32  result, to LO.
- `remainder`  out  32  result, to HI.
- `div_end`  out  1  one-cycle completion pulse; results are valid in that cycle and held afterwards.
- `div_busy`  out  1  high in BUSY; debug/display only.

## Operation
- States:
  - IDLE: waits.
  - BUSY: runs iterations. A 6-bit counter counts from 0 to 31.
  - DONE: single cycle with `div_end`=1.
- IDLE→BUSY when `div_begin`=1. On that edge:
  - latch |op1| and |op2| (absolute values when `div_signed`, raw otherwise);
  - latch sign flags q_neg = s1^s2 and r_neg = s1;
  - clear the partial remainder and the counter.
- BUSY iteration (restoring):
  - {rem,quo} shifts left 1.
  - If rem_shifted ≥ divisor (33-bit compare): rem -= divisor and quo[0]=1.
  - The counter increments.
- BUSY→DONE after iteration 31 completes. On that edge the outputs register the sign-corrected values:
  - `quotient` = q_neg ? −quo : quo;
  - `remainder` = r_neg ? −rem : rem.
- DONE→IDLE unconditionally. If `div_begin` is still high in IDLE (back-to-back divides), a new start occurs on the next edge.
- Cancel: `div_begin`=0 in any BUSY cycle → IDLE next edge, no `div_end`, outputs unchanged.
- Divide by zero: no trap. Unsigned result is quo=0xFFFFFFFF, rem=op1. Signed result applies the same sign correction to these magnitudes. This behaviour is deterministic and tested.
- 0x80000000 / −1 signed: magnitude arithmetic is done in 32-bit unsigned, so quotient = 0x80000000 and remainder = 0. There is no overflow flag.
- Reset: state IDLE, counter 0, `quotient`=0, `remainder`=0, `div_end`=0, `div_busy`=0. Reset mid-BUSY aborts with no `div_end`.

## Timing
- Start edge at cycle N (IDLE, `div_begin`=1).
- BUSY runs cycles N+1..N+32.
- `div_end`=1 in cycle N+33 only.
- Total latency is 33 cycles from the start edge to the `div_end` cycle.
- EXE_over = EXE_valid & (~divide | div_end). The instruction leaves EXE at the end of cycle N+33.
- Outputs are registered. There is no combinational path from inputs to `div_end`, `quotient` or `remainder`.
- Operand or `div_signed` changes after the start edge are ignored.

## Structure
- Shared package (cpu_pkg):
  - state encoding constants DIV_IDLE, DIV_BUSY, DIV_DONE;
  - DIV_ITER = 32;
  - macro/function for two's-complement absolute value.
- One combinational sub-module `div_step` is natural: it takes {rem,quo} and the divisor and returns the next {rem,quo}. It is instantiated once.
- The HI/LO write selection (hi_write/lo_write for divide) lives in the EXE stage, not here.

## Test plan
- DIVU 100/7, start at cycle N → `div_end` only at N+33; quotient=14, remainder=2; `div_end` low in N+34.
- DIV −7/2 (0xFFFFFFF9, 0x2) → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. DIV 7/−2 → 0xFFFFFFFD and 1.
- DIV 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0. DIVU same operands → quotient=0, remainder=0x80000000.
- DIVU 0x12345678/0 → quotient=0xFFFFFFFF, remainder=0x12345678 after 33 cycles; no hang.
- Cancel and reset:
  - Drop `div_begin` at BUSY cycle 10 → IDLE, no `div_end`, previous results held.
  - Restart 50/5 → q=10, r=0 with full 33-cycle latency.
  - Assert `reset` mid-BUSY → all outputs 0, no `div_end`.
- Back-to-back: hold `div_begin` high across two divides (operands change on the cycle after `div_end`) → two `div_end` pulses 34 cycles apart, each with correct results.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the iterative divider: FSM states, iteration count
// and the two's-complement magnitude helper.
package divider_pkg;

  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // 0x80000000 maps to itself, which is what the unsigned magnitude datapath wants.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/divider_if.sv
// Start/finish handshake between the EXE stage (master) and the divider (slave).
interface divider_if #(parameter int WIDTH = 32);
  logic             div_begin;
  logic             div_signed;
  logic [WIDTH-1:0] div_op1;
  logic [WIDTH-1:0] div_op2;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_end;
  logic             div_busy;

  modport master (
    output div_begin, div_signed, div_op1, div_op2,
    input  quotient, remainder, div_end, div_busy
  );

  modport slave (
    input  div_begin, div_signed, div_op1, div_op2,
    output quotient, remainder, div_end, div_busy
  );
endinterface

// File: rtl/divider_step.sv
// One restoring radix-2 iteration: shift {rem,quo} left, subtract the divisor
// when the shifted remainder is large enough and record a quotient bit.
module div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, divisor};
    ge       = (shifted >= {1'b0, divisor});
    rem_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ge};
  end
endmodule

// File: rtl/divider.sv
// Iterative 32-bit signed/unsigned divider answering EXE's div_begin/div_end
// handshake; quotient goes to LO and remainder to HI.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  divider_if.slave   bus
);
  localparam logic [5:0] LAST_ITER = 6'(DIV_ITER - 1);

  div_state_e       state, state_next;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] rem, quo, divisor;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] quotient_r, remainder_r;
  logic             q_neg, r_neg;
  logic             load, step_en, finish;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_next;
  end

  // Dropping div_begin while busy cancels silently; results stay untouched.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step_en    = 1'b0;
    finish     = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (bus.div_begin) begin
          state_next = DIV_BUSY;
          load       = 1'b1;
        end
      end
      DIV_BUSY: begin
        if (!bus.div_begin) begin
          state_next = DIV_IDLE;
        end else begin
          step_en = 1'b1;
          if (cnt == LAST_ITER) begin
            state_next = DIV_DONE;
            finish     = 1'b1;
          end
        end
      end
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else begin
      if (load) begin
        quo     <= bus.div_signed ? abs32(bus.div_op1) : bus.div_op1;
        divisor <= bus.div_signed ? abs32(bus.div_op2) : bus.div_op2;
        rem     <= '0;
        cnt     <= '0;
        q_neg   <= bus.div_signed & (bus.div_op1[WIDTH-1] ^ bus.div_op2[WIDTH-1]);
        r_neg   <= bus.div_signed & bus.div_op1[WIDTH-1];
      end else if (step_en) begin
        rem <= rem_step;
        quo <= quo_step;
        cnt <= cnt + 6'd1;
      end
      // The last iteration's result is sign-corrected straight into the output registers.
      if (finish) begin
        quotient_r  <= q_neg ? (~quo_step + 1'b1) : quo_step;
        remainder_r <= r_neg ? (~rem_step + 1'b1) : rem_step;
      end
    end
  end

  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.div_end   = (state == DIV_DONE);
  assign bus.div_busy  = (state == DIV_BUSY);
endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the divider: latency, signed/unsigned
// corner cases, divide by zero, cancel, reset mid-operation and back-to-back.
module tb_divider;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  divider_if #(.WIDTH(32)) bus ();

  divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic b, input logic sgn,
                               input logic [31:0] a, input logic [31:0] d);
    bus.div_begin  = b;
    bus.div_signed = sgn;
    bus.div_op1    = a;
    bus.div_op2    = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Starts a divide, scrambles the operands after the start edge, and checks
  // the 33-cycle latency, both results and that div_end lasts one cycle.
  task automatic run_divide(input string tag, input logic sgn,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_q, input logic [31:0] exp_r);
    int lat;
    @(negedge clk);
    applyStimulus(1'b1, sgn, a, d);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, ~sgn, ~a, 32'h5);
    lat = 1;
    while (!bus.div_end && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'd33);
    checkOutput({tag, " quotient"}, bus.quotient, exp_q);
    checkOutput({tag, " remainder"}, bus.remainder, exp_r);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput({tag, " end low"}, {31'b0, bus.div_end}, 32'd0);
  endtask

  initial begin
    logic saw_end;
    int   lat;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("reset quotient", bus.quotient, 32'h0);
    checkOutput("reset remainder", bus.remainder, 32'h0);
    checkOutput("reset end", {31'b0, bus.div_end}, 32'd0);
    checkOutput("reset busy", {31'b0, bus.div_busy}, 32'd0);
    reset = 1'b0;

    run_divide("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_divide("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_divide("div 7/-2", 1'b1, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1);
    run_divide("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    run_divide("divu min/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_divide("divu by zero", 1'b0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678);
    run_divide("div -8/0", 1'b1, 32'hFFFF_FFF8, 32'h0, 32'h0000_0001, 32'hFFFF_FFF8);

    // Cancel in the tenth busy cycle.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'd1000, 32'd3);
    @(posedge clk);
    repeat (10) @(negedge clk);
    checkOutput("cancel busy before", {31'b0, bus.div_busy}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("cancel busy after", {31'b0, bus.div_busy}, 32'd0);
    saw_end = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.div_end) saw_end = 1'b1;
    end
    checkOutput("cancel no end", {31'b0, saw_end}, 32'd0);
    checkOutput("cancel held q", bus.quotient, 32'h0000_0001);
    checkOutput("cancel held r", bus.remainder, 32'hFFFF_FFF8);

    run_divide("divu 50/5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0);

    // Reset in the middle of a busy divide.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FF00, 32'd3);
    @(posedge clk);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("midreset quotient", bus.quotient, 32'h0);
    checkOutput("midreset remainder", bus.remainder, 32'h0);
    checkOutput("midreset busy", {31'b0, bus.div_busy}, 32'd0);
    checkOutput("midreset end", {31'b0, bus.div_end}, 32'd0);
    reset = 1'b0;
    saw_end = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.div_end) saw_end = 1'b1;
    end
    checkOutput("midreset no end", {31'b0, saw_end}, 32'd0);

    // Back-to-back: div_begin stays high, operands change after the first div_end.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'd100, 32'd7);
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    while (!bus.div_end && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b first latency", 32'(lat), 32'd33);
    checkOutput("b2b first q", bus.quotient, 32'd14);
    checkOutput("b2b first r", bus.remainder, 32'd2);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'd50, 32'd5);
    lat = 1;
    while (!bus.div_end && lat < 45) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b spacing", 32'(lat), 32'd34);
    checkOutput("b2b second q", bus.quotient, 32'd10);
    checkOutput("b2b second r", bus.remainder, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("b2b end low", {31'b0, bus.div_end}, 32'd0);
    @(negedge clk);
    checkOutput("b2b idle", {31'b0, bus.div_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
